// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_arbiter                                                           |
// | Two-requester round-robin arbiter feeding one 8N1 UART transmitter. A     |
// | requester keeps the line locked until it sends 0x0A (end of line).        |
// | Optional: define UART_ARB_TIMEOUT_EN to release an idle lock after        |
// | TimeoutCycles cycles.                                                     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module uart_tx_arbiter #(
    parameter int ClkFreq       = 50000000,
    parameter int BaudRate      = 115200,
    parameter int TimeoutCycles = 65535
) (
    input  logic       clk_sys_i,
    input  logic       rst_sys_ni,
    input  logic       req0_valid_i,
    input  logic [7:0] req0_data_i,
    output logic       req0_ready_o,
    input  logic       req1_valid_i,
    input  logic [7:0] req1_data_i,
    output logic       req1_ready_o,
    output logic       uart_tx_o,
    output logic [1:0] grant_o,
    output logic       busy_o
);

    localparam int ClksPerBit = ClkFreq / BaudRate;
    localparam int CntW       = (ClksPerBit > 2) ? $clog2(ClksPerBit) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [0:0] A_FREE   = 1'b0;
    localparam logic [0:0] A_LOCKED = 1'b1;

    if (ClksPerBit < 2) begin : g_bad_baud
        $error("uart_tx_arbiter: ClkFreq/BaudRate must be at least 2");
    end
    if (TimeoutCycles < 1) begin : g_bad_timeout
        $error("uart_tx_arbiter: TimeoutCycles must be at least 1");
    end

    logic [1:0]      ser_state;
    logic [CntW-1:0] bit_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            tx_q;

    logic [0:0]      arb_state;
    logic            owner;
    logic            ptr;
    logic            release_pend;
    logic            armed;

    logic            cnt_last;
    logic            ser_idle;
    logic            frame_done;
    logic            locked;
    logic            sel;
    logic            has_grant;
    logic            handshake;
    logic            timeout_hit;
    logic [7:0]      hs_data;

    assign cnt_last   = (bit_cnt == CntW'(ClksPerBit - 1));
    assign ser_idle   = (ser_state == S_IDLE);
    assign frame_done = (ser_state == S_STOP) && cnt_last;
    assign locked     = (arb_state == A_LOCKED);

    // In FREE a lone requester wins; a tie goes to the round-robin pointer.
    assign sel = locked ? owner
               : ((req0_valid_i && req1_valid_i) ? ptr : req1_valid_i);

    // armed keeps grants off until the first edge after reset release.
    assign has_grant = armed && (locked || req0_valid_i || req1_valid_i);

    assign grant_o      = has_grant ? (sel ? 2'b10 : 2'b01) : 2'b00;
    assign req0_ready_o = has_grant && ser_idle && !sel;
    assign req1_ready_o = has_grant && ser_idle && sel;

    assign handshake = (req0_ready_o && req0_valid_i) || (req1_ready_o && req1_valid_i);
    assign hs_data   = sel ? req1_data_i : req0_data_i;

    assign uart_tx_o = tx_q;
    assign busy_o    = !ser_idle;

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            ser_state <= S_IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            tx_q      <= 1'b1;
        end else begin
            case (ser_state)
                S_IDLE: begin
                    if (handshake) begin
                        ser_state <= S_START;
                        shreg     <= hs_data;
                        bit_cnt   <= '0;
                        tx_q      <= 1'b0;
                    end
                end
                S_START: begin
                    if (cnt_last) begin
                        ser_state <= S_DATA;
                        bit_cnt   <= '0;
                        bit_idx   <= '0;
                        tx_q      <= shreg[0];
                    end else begin
                        bit_cnt <= bit_cnt + CntW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_last) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            ser_state <= S_STOP;
                            tx_q      <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx_q    <= shreg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CntW'(1);
                    end
                end
                default: begin
                    if (cnt_last) begin
                        ser_state <= S_IDLE;
                        bit_cnt   <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + CntW'(1);
                    end
                end
            endcase
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int ToW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    logic [ToW-1:0] to_cnt;
    logic           owner_valid;
    logic           idle_owner;

    assign owner_valid = owner ? req1_valid_i : req0_valid_i;
    assign idle_owner  = locked && ser_idle && !owner_valid;
    assign timeout_hit = idle_owner && (to_cnt == ToW'(TimeoutCycles - 1));

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            to_cnt <= '0;
        end else if (idle_owner && !timeout_hit) begin
            to_cnt <= to_cnt + ToW'(1);
        end else begin
            to_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // An end-of-line byte holds the lock until its own frame has left the line.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            arb_state    <= A_FREE;
            owner        <= 1'b0;
            ptr          <= 1'b0;
            release_pend <= 1'b0;
            armed        <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (handshake) begin
                arb_state    <= A_LOCKED;
                owner        <= sel;
                release_pend <= (hs_data == 8'h0A);
            end else if (frame_done && release_pend) begin
                arb_state    <= A_FREE;
                ptr          <= ~owner;
                release_pend <= 1'b0;
            end else if (timeout_hit) begin
                arb_state <= A_FREE;
                ptr       <= ~owner;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_tx_arbiter                                                        |
// | Directed self-checking bench, ClksPerBit = 4, TimeoutCycles = 20.         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v0 = 1'b0;
    logic       v1 = 1'b0;
    logic [7:0] d0 = 8'h00;
    logic [7:0] d1 = 8'h00;
    logic       rdy0;
    logic       rdy1;
    logic       tx;
    logic [1:0] grant;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    uart_tx_arbiter #(
        .ClkFreq       (1000000),
        .BaudRate      (250000),
        .TimeoutCycles (20)
    ) dut (
        .clk_sys_i    (clk),
        .rst_sys_ni   (rst_n),
        .req0_valid_i (v0),
        .req0_data_i  (d0),
        .req0_ready_o (rdy0),
        .req1_valid_i (v1),
        .req1_data_i  (d1),
        .req1_ready_o (rdy1),
        .uart_tx_o    (tx),
        .grant_o      (grant),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    // Stimulus helper: stops on the negedge where the chosen ready is high.
    task automatic wait_ready(input int which, output bit ok, output int waited);
        ok = 1'b0;
        waited = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            waited++;
            if ((which == 0) ? rdy0 : rdy1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        v0 = 1'b0;
        v1 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        v0 = 1'b1;
        v1 = 1'b1;
        #1;
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL rst_tx: got %b want 1", tx); end
        vectors++; if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b%b want 00", rdy1, rdy0); end
        vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL rst_grant: got %b want 00", grant); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL rel_grant_early: got %b want 00", grant); end
        @(negedge clk);
        vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL rel_grant: got %b want 01", grant); end
        vectors++; if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin miscompares++; $display("FAIL rel_ready: got %b%b want 01", rdy1, rdy0); end
        v0 = 1'b0;
        v1 = 1'b0;
    endtask

    task automatic test_single_frame();
        logic [7:0] byte_v;
        logic       exp;
        bit         ok;
        int         waited;
        byte_v = 8'h0A;
        d0 = byte_v;
        v0 = 1'b1;
        wait_ready(0, ok, waited);
        vectors++; if (!ok) begin miscompares++; $display("FAIL sf_ready_timeout: got 0 want 1"); end
        vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL sf_grant: got %b want 01", grant); end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k <= 4) exp = 1'b0;
            else if (k <= 36) exp = byte_v[(k - 5) / 4];
            else exp = 1'b1;
            vectors++; if (tx !== exp) begin miscompares++; $display("FAIL sf_tx k=%0d: got %b want %b", k, tx, exp); end
            if (k == 1) begin
                vectors++; if (rdy0 !== 1'b0) begin miscompares++; $display("FAIL sf_ready_busy: got %b want 0", rdy0); end
                vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL sf_busy: got %b want 1", busy); end
            end
        end
        @(negedge clk);
        vectors++; if (rdy0 !== 1'b1) begin miscompares++; $display("FAIL sf_ready_n41: got %b want 1", rdy0); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL sf_busy_end: got %b want 0", busy); end
        v0 = 1'b0;
    endtask

    task automatic test_round_robin();
        bit ok;
        int waited;
        do_reset();
        d0 = 8'h0A;
        d1 = 8'h0A;
        v0 = 1'b1;
        v1 = 1'b1;
        wait_ready(0, ok, waited);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rr_ready0_timeout: got 0 want 1"); end
        vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL rr_grant0: got %b want 01", grant); end
        vectors++; if (rdy1 !== 1'b0) begin miscompares++; $display("FAIL rr_ready1_low: got %b want 0", rdy1); end
        @(negedge clk);
        v0 = 1'b0;
        vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL rr_start0: got %b want 0", tx); end
        wait_ready(1, ok, waited);
        vectors++; if (!ok || waited != 40) begin miscompares++; $display("FAIL rr_ready1_cycle: got %0d want 40", waited); end
        vectors++; if (grant !== 2'b10) begin miscompares++; $display("FAIL rr_grant1: got %b want 10", grant); end
        @(negedge clk);
        v1 = 1'b0;
        vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL rr_start1: got %b want 0", tx); end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_lock();
        logic [7:0] bytes_v [3];
        logic [7:0] d1_v;
        bit         ok;
        int         waited;
        int         leaks;
        bytes_v[0] = 8'h41;
        bytes_v[1] = 8'h42;
        bytes_v[2] = 8'h0A;
        d1_v = 8'h55;
        do_reset();
        d1 = d1_v;
        v1 = 1'b1;
        v0 = 1'b1;
        leaks = 0;
        for (int b = 0; b < 3; b++) begin
            d0 = bytes_v[b];
            ok = 1'b0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (rdy1) leaks++;
                if (rdy0) begin
                    ok = 1'b1;
                    break;
                end
            end
            vectors++; if (!ok) begin miscompares++; $display("FAIL lk_ready0 byte=%0d: got 0 want 1", b); end
            @(negedge clk);
            if (rdy1) leaks++;
        end
        v0 = 1'b0;
        vectors++; if (leaks != 0) begin miscompares++; $display("FAIL lk_ready1_leak: got %0d want 0", leaks); end
        wait_ready(1, ok, waited);
        vectors++; if (!ok || waited != 40) begin miscompares++; $display("FAIL lk_ready1_cycle: got %0d want 40", waited); end
        vectors++; if (grant !== 2'b10) begin miscompares++; $display("FAIL lk_grant1: got %b want 10", grant); end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) v1 = 1'b0;
            if (k >= 5 && k <= 36 && ((k - 5) % 4) == 1) begin
                vectors++;
                if (tx !== d1_v[(k - 5) / 4]) begin
                    miscompares++;
                    $display("FAIL lk_req1_bit%0d: got %b want %b", (k - 5) / 4, tx, d1_v[(k - 5) / 4]);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bit ok;
        int waited;
        do_reset();
        d0 = 8'h41;
        v0 = 1'b1;
        v1 = 1'b1;
        wait_ready(0, ok, waited);
        vectors++; if (!ok) begin miscompares++; $display("FAIL to_ready0_timeout: got 0 want 1"); end
        @(negedge clk);
        v0 = 1'b0;
        repeat (59) @(negedge clk);
        vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL to_grant_n60: got %b want 01", grant); end
        @(negedge clk);
`ifdef UART_ARB_TIMEOUT_EN
        vectors++; if (grant !== 2'b10) begin miscompares++; $display("FAIL to_grant_n61: got %b want 10", grant); end
        vectors++; if (rdy1 !== 1'b1) begin miscompares++; $display("FAIL to_ready1: got %b want 1", rdy1); end
`else
        vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL to_grant_n61: got %b want 01", grant); end
        repeat (40) @(negedge clk);
        vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL to_grant_n101: got %b want 01", grant); end
        vectors++; if (rdy1 !== 1'b0) begin miscompares++; $display("FAIL to_ready1: got %b want 0", rdy1); end
`endif
        v1 = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int waited;
        int high_cnt;
        do_reset();
        d0 = 8'h55;
        v0 = 1'b1;
        wait_ready(0, ok, waited);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rm_ready0_timeout: got 0 want 1"); end
        @(negedge clk);
        v0 = 1'b0;
        repeat (9) @(negedge clk);
        vectors++; if (tx !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL rm_data_bit1: got tx=%b busy=%b want tx=0 busy=1", tx, busy); end
        #2;
        rst_n = 1'b0;
        v0 = 1'b1;
        v1 = 1'b1;
        #1;
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL rm_async_tx: got %b want 1", tx); end
        vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL rm_async_grant: got %b want 00", grant); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rm_async_busy: got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL rm_regrant: got %b want 01", grant); end
        vectors++; if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin miscompares++; $display("FAIL rm_ready: got %b%b want 01", rdy1, rdy0); end
        v0 = 1'b0;
        v1 = 1'b0;
        high_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (tx === 1'b1 && busy === 1'b0) high_cnt++;
        end
        vectors++; if (high_cnt != 12) begin miscompares++; $display("FAIL rm_no_resume: got %0d want 12", high_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_lock();
        test_timeout();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
